// File: rtl/nbit_serializer.sv
// MSB-first parallel-to-serial converter with a valid/ready load port.
// Define PARITY_EN to append an even-parity bit to every frame (N+1 bits per frame).
module nbit_serializer #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] d,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         frame_start,
  output logic         last_bit
);

  localparam int            CW      = $clog2(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]    state;
  logic [N-1:0]  shreg;
  logic [CW-1:0] cnt;
  logic          at_last;
  logic          xfer;
`ifdef PARITY_EN
  logic          par;
`endif

  assign at_last = (cnt == '0);
  assign xfer    = load_valid & load_ready;

  // Outputs depend only on state, so load_ready never loops back through load_valid.
  always_comb begin
    load_ready  = 1'b0;
    sout        = 1'b0;
    sout_valid  = 1'b0;
    frame_start = 1'b0;
    last_bit    = 1'b0;
    case (state)
      IDLE: load_ready = 1'b1;
      SHIFT: begin
        sout        = shreg[N-1];
        sout_valid  = 1'b1;
        frame_start = (cnt == CNT_MAX);
`ifndef PARITY_EN
        last_bit    = at_last;
        load_ready  = at_last;
`endif
      end
`ifdef PARITY_EN
      PARITY: begin
        sout       = par;
        sout_valid = 1'b1;
        last_bit   = 1'b1;
        load_ready = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
`ifdef PARITY_EN
      par   <= 1'b0;
`endif
    end else if (xfer) begin
      shreg <= d;
      cnt   <= CNT_MAX;
      state <= SHIFT;
`ifdef PARITY_EN
      par   <= ^d;
`endif
    end else begin
      case (state)
        SHIFT: begin
          shreg <= {shreg[N-2:0], 1'b0};
          if (!at_last) cnt <= cnt - 1'b1;
`ifdef PARITY_EN
          else          state <= PARITY;
`else
          else          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_serializer.sv
// Self-checking bench for nbit_serializer: queue-of-frame-bits reference model,
// directed literal scenarios, then randomized load/reset traffic.
module tb_nbit_serializer;
  localparam int N = 4;
`ifdef PARITY_EN
  localparam int FL  = N + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = N;
  localparam bit PAR = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         load_valid = 1'b0;
  logic [N-1:0] d = '0;
  logic         load_ready, sout, sout_valid, frame_start, last_bit;

  nbit_serializer #(.N(N)) dut (
    .CLK(CLK), .RST(RST), .d(d), .load_valid(load_valid), .load_ready(load_ready),
    .sout(sout), .sout_valid(sout_valid), .frame_start(frame_start), .last_bit(last_bit)
  );

  always #5 CLK = ~CLK;

  // Model: the bits still to be emitted for the current frame, front = this cycle.
  typedef struct { bit s; bit fs; bit lb; } fbit_t;
  fbit_t q[$];

  int nchk = 0;
  int nerr = 0;
  logic [15:0] hs, hv, hf;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (RST) q.delete();
    else if (load_valid && q.size() <= 1) begin
      q.delete();
      for (int i = N - 1; i >= 0; i--) begin
        fbit_t b;
        b.s = d[i]; b.fs = (i == N - 1); b.lb = (i == 0) && !PAR;
        q.push_back(b);
      end
      if (PAR) begin
        fbit_t p;
        p.s = ^d; p.fs = 1'b0; p.lb = 1'b1;
        q.push_back(p);
      end
    end else if (q.size() > 0) void'(q.pop_front());
  endtask

  // One clock: drive inputs, advance model at the edge, compare at the falling edge.
  task automatic cyc(input logic r, input logic lv, input logic [N-1:0] dv);
    logic [4:0] exp;
    RST = r; load_valid = lv; d = dv;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    if (q.size() == 0) exp = 5'b10000;
    else exp = {q.size() == 1, 1'b1, q[0].fs, q[0].lb, q[0].s};
    chk("outputs{ready,valid,fs,lb,sout}",
        {27'd0, load_ready, sout_valid, frame_start, last_bit, sout}, {27'd0, exp});
    hs = {hs[14:0], sout};
    hv = {hv[14:0], sout_valid};
    hf = {hf[14:0], frame_start};
  endtask

  initial begin
    hs = '0; hv = '0; hf = '0;
    cyc(1, 0, '0);
    chk("reset_state", {27'd0, sout, sout_valid, frame_start, last_bit, load_ready}, 32'b00001);

    // Single frame 1011
    hs = '0; hf = '0;
    cyc(0, 1, 4'b1011);
    for (int i = 1; i < FL; i++) cyc(0, 0, '0);
`ifdef PARITY_EN
    chk("single_1011_bits", {27'd0, hs[4:0]}, 32'b10111);
    chk("single_1011_fs", {27'd0, hf[4:0]}, 32'b10000);
    hs = '0;
    cyc(0, 1, 4'b0110);
    for (int i = 1; i < FL; i++) cyc(0, 0, '0);
    chk("single_0110_parity", {27'd0, hs[4:0]}, 32'b01100);
`else
    chk("single_1011_bits", {28'd0, hs[3:0]}, 32'b1011);
    chk("single_1011_fs", {28'd0, hf[3:0]}, 32'b1000);
`endif
    chk("last_bit_at_end", {31'd0, last_bit}, 32'd1);
    cyc(0, 0, '0);
    chk("idle_after_frame", {30'd0, sout_valid, load_ready}, 32'b01);

    // Back-to-back with load_valid held high
    hs = '0; hv = '0; hf = '0;
    cyc(0, 1, 4'b1011);
    for (int i = 1; i < FL; i++) cyc(0, 1, 4'b0110);
    cyc(0, 1, 4'b0110);
    for (int i = 1; i < FL; i++) cyc(0, 0, '0);
`ifdef PARITY_EN
    chk("b2b_bits", {22'd0, hs[9:0]}, 32'b1011101100);
    chk("b2b_valid", {22'd0, hv[9:0]}, 32'h3FF);
    chk("b2b_fs", {22'd0, hf[9:0]}, 32'b1000010000);
`else
    chk("b2b_bits", {24'd0, hs[7:0]}, 32'b10110110);
    chk("b2b_valid", {24'd0, hv[7:0]}, 32'hFF);
    chk("b2b_fs", {24'd0, hf[7:0]}, 32'b10001000);
`endif
    cyc(0, 0, '0);

    // d changes mid-frame while load_valid is high: ignored until last bit
    hs = '0;
    cyc(0, 1, 4'b1111);
    for (int i = 1; i < FL; i++) cyc(0, 1, 4'b0000);
`ifdef PARITY_EN
    chk("midframe_ignored", {27'd0, hs[4:0]}, 32'b11110);
`else
    chk("midframe_ignored", {28'd0, hs[3:0]}, 32'b1111);
`endif
    cyc(0, 1, 4'b0000);
    chk("accept_at_last", {29'd0, frame_start, sout_valid, sout}, 32'b110);
    for (int i = 1; i < FL + 1; i++) cyc(0, 0, '0);

    // Reset mid-frame
    cyc(0, 1, 4'b1011);
    cyc(0, 0, '0);
    cyc(1, 0, '0);
    chk("abort_reset", {30'd0, sout_valid, load_ready}, 32'b01);
    hs = '0;
    cyc(0, 1, 4'b0001);
    for (int i = 1; i < FL; i++) cyc(0, 0, '0);
`ifdef PARITY_EN
    chk("after_abort_frame", {27'd0, hs[4:0]}, 32'b00011);
`else
    chk("after_abort_frame", {28'd0, hs[3:0]}, 32'b0001);
`endif
    cyc(0, 0, '0);

    // Reset wins over a simultaneous load
    hv = '0;
    cyc(1, 1, 4'b1111);
    cyc(0, 0, '0);
    cyc(0, 0, '0);
    chk("reset_drops_load", {29'd0, hv[2:0]}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, N'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/nbit_serializer.md
NBIT_SERIALIZER -- requirements
Module: nbit_serializer

Interface
REQ-001 Parameter N, default 4, data word width; the legal range SHALL be N >= 2.
REQ-002 CLK  input  1  the only clock; all state SHALL update on the rising edge.
REQ-003 RST  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-004 d  input  N  parallel word to transmit.
REQ-005 load_valid  input  1  d is valid and requested for transmission.
REQ-006 load_ready  output  1  the block can accept d in this cycle; a transfer SHALL occur on a rising edge where load_valid and load_ready are both 1.
REQ-007 sout  output  1  serial data, MSB first.
REQ-008 sout_valid  output  1  sout carries a frame bit in this cycle.
REQ-009 frame_start  output  1  high during the first bit of each frame.
REQ-010 last_bit  output  1  high during the final bit of each frame.

Function
REQ-011 States SHALL be IDLE, SHIFT and, when PARITY_EN is defined, PARITY.
REQ-012 IDLE: load_ready=1; sout, sout_valid, frame_start and last_bit SHALL all be 0.
REQ-013 Transfer in any state: on that edge, capture d into the shift register, set the bit counter to N-1, and enter SHIFT.
REQ-014 Latency: the word SHALL be accepted at edge k, and its MSB SHALL appear on sout with sout_valid=1 in the cycle following edge k.
REQ-015 SHIFT: sout=shreg[N-1] and sout_valid=1.
- Each edge: shift left by one and decrement the counter.
- frame_start=1 only in the first bit cycle.
REQ-016 SHIFT with counter==0 is the final data bit.
- Without PARITY_EN: last_bit=1, load_ready=1, then go to IDLE, or back to SHIFT if a transfer occurs.
- With PARITY_EN: load_ready=0, last_bit=0, then go to PARITY.
REQ-017 PARITY: sout = even-parity bit (XOR of the N captured data bits, computed at capture); sout_valid=1, last_bit=1, load_ready=1; then go to IDLE, or to SHIFT on a transfer.
REQ-018 Back-to-back: a transfer during a last_bit cycle SHALL start the next frame in the immediately following cycle, with no idle gap and frame_start=1.
REQ-019 load_ready SHALL be 0 in all non-final SHIFT cycles; load_valid SHALL be ignored there, and d SHALL have no effect.
REQ-020 The shift register SHALL shift in 0 at the LSB; the counter SHALL be ceil(log2 N) bits wide and SHALL never wrap below 0.

Reset
REQ-021 RST=1 at an edge SHALL force IDLE, shift register 0, counter 0 and parity 0.
- In the following cycle: sout=0, sout_valid=0, frame_start=0, last_bit=0, load_ready=1.
REQ-022 RST SHALL take priority over a simultaneous transfer; that word SHALL be dropped.
REQ-023 RST mid-frame SHALL abort the frame immediately; no remaining bits SHALL be emitted.

Configuration
REQ-024 Macro PARITY_EN defined: each frame SHALL be N+1 bits (data plus even parity) with the PARITY state compiled in.
REQ-025 PARITY_EN undefined: each frame SHALL be N bits; no PARITY state or parity register SHALL exist.

Verification
REQ-026 N=4, load 1011 once -> sout 1,0,1,1 in the 4 cycles after the load edge; frame_start on bit 1; last_bit on bit 4; then IDLE with sout_valid=0.
REQ-027 PARITY_EN, load 1011 -> sout 1,0,1,1,1 (parity=1); load 0110 -> parity bit 0; last_bit only on the parity cycle.
REQ-028 load_valid held high with 1011 then 0110 -> sout 1,0,1,1,0,1,1,0 contiguous, sout_valid never low, frame_start on cycles 1 and 5.
REQ-029 load 1111, then change d to 0000 with load_valid=1 during bits 2-3 -> output unchanged at 1,1,1,1; 0000 accepted only at the last_bit edge.
REQ-030 load 1011, RST=1 during bit 2 -> next cycle sout_valid=0 and load_ready=1; load 0001 next -> clean frame 0,0,0,1.
REQ-031 RST=1 and load_valid=1 with d=1111 on the same edge -> no frame emitted; sout_valid stays 0.
